osd_dii_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges N DII flit streams into one DII output without ever interleaving flits of different packets. It sits in front of the host interface module's DII ingress port (the `dii_in` side) so that several debug-module sources can share the single host egress path. The grant is locked from the first flit to the `last` flit of a packet. An optional watchdog flags a granted source that stalls mid-packet.

---
 rtl/osd_dii_pkt_arbiter.sv | 133 +++++++++++++
 tb/tb_osd_dii_pkt_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_dii_pkt_arbiter.sv
// Packet-level round-robin arbiter merging N DII flit streams without interleaving packets.
// Optional stall watchdog enabled by defining OSD_DII_PKT_ARBITER_WATCHDOG_EN.
module osd_dii_pkt_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*N-1:0]      in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt, grant_nxt;
  logic [IW-1:0]  pick, sel;
  logic           pick_found;
  logic           xfer;
  int unsigned    idx;
  logic [15:0]    data_arr [N];

  if (N < 2 || N > 16 || TIMEOUT < 2) begin : g_cfg_check
    $error("osd_dii_pkt_arbiter: N must be 2..16 and TIMEOUT >= 2");
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_split
    assign data_arr[i] = in_data[16*i +: 16];
  end

  // Round-robin search from ptr upward, wrapping modulo N
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_found && in_valid[IW'(idx)]) begin
        pick       = IW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign sel  = (state == BUSY) ? grant_id : pick;
  assign xfer = out_valid && out_ready;
  assign busy = (state == BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  // Next-state: lock on a non-last first flit, release on the last flit
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    case (state)
      IDLE: begin
        if (xfer) begin
          ptr_nxt = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
          if (!out_last) begin
            state_nxt = BUSY;
            grant_nxt = pick;
          end
        end
      end
      BUSY: begin
        if (xfer && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux; everything is quiet while reset is held
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (rst && (state == BUSY || pick_found)) begin
      out_valid     = in_valid[sel];
      out_data      = data_arr[sel];
      out_last      = in_last[sel];
      in_ready[sel] = out_ready;
    end
  end

`ifdef OSD_DII_PKT_ARBITER_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;
  logic          err_q;

  // Saturating stall counter; error latches one edge after it hits TIMEOUT
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (stall_cnt == CW'(TIMEOUT)) err_q <= 1'b1;
      if (state != BUSY || xfer) stall_cnt <= '0;
      else if (stall_cnt != CW'(TIMEOUT)) stall_cnt <= stall_cnt + CW'(1);
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_osd_dii_pkt_arbiter.sv
// Scoreboard bench for osd_dii_pkt_arbiter: a packet-level reference model predicts every
// cycle's handshake view and every delivered flit; a negedge monitor compares.
module tb_osd_dii_pkt_arbiter;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int IW = $clog2(N);

  logic              clk = 1'b1;
  logic              rst;
  logic [16*N-1:0]   in_data;
  logic [N-1:0]      in_valid, in_last, in_ready;
  logic [15:0]       out_data;
  logic              out_valid, out_last, out_ready;
  logic [IW-1:0]     grant_id;
  logic              busy, err_timeout;

  osd_dii_pkt_arbiter #(.N(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rdy;
    logic         ov;
    logic [15:0]  od;
    logic         ol;
    logic         bsy;
    logic [IW-1:0] gid;
    logic         err;
    logic         known;
    logic         gchk;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } flit_t;

  exp_t  cq[$];
  flit_t fq[$];

  int total = 0;
  int bad   = 0;

  // Stimulus for the current cycle
  logic [N-1:0] v, l;
  logic [15:0]  d [N];
  logic         r, rn;

  // Reference model: who owns the output, round-robin start, watchdog
  int   owner   = -1;
  int   rr_ptr  = 0;
  int   mgid    = 0;
  int   wd_cnt  = 0;
  logic m_err   = 1'b0;
  logic init    = 1'b0;
  logic gid_rst = 1'b0;

  // Random packet sources
  int seq [N];
  int rem [N];
  int len_lo, len_hi, vpct, rpct;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    flit_t f;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("in_ready",  32'(in_ready),  32'(e.rdy));
      chk("out_valid", 32'(out_valid), 32'(e.ov));
      chk("out_data",  32'(out_data),  32'(e.od));
      chk("out_last",  32'(out_last),  32'(e.ol));
      if (e.known) begin
        chk("busy",        32'(busy),        32'(e.bsy));
        chk("err_timeout", 32'(err_timeout), 32'(e.err));
        if (e.gchk) chk("grant_id", 32'(grant_id), 32'(e.gid));
      end
    end
    if (out_valid && out_ready) begin
      if (fq.size() == 0) chk("unexpected_flit", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        f = fq.pop_front();
        chk("flit_data", 32'(out_data), 32'(f.d));
        chk("flit_last", 32'(out_last), 32'(f.l));
      end
    end
  end

  // Apply one cycle of stimulus, predict the outcome, advance the model at the edge
  task automatic cyc(output int xs);
    exp_t  e;
    flit_t f;
    int    sel;
    int    j;
    logic  xf;
    rst = rn;
    out_ready = r;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = v[i];
      in_last[i]  = l[i];
      in_data[16*i +: 16] = d[i];
    end
    sel = -1;
    if (rn) begin
      if (owner >= 0) sel = owner;
      else begin
        for (int k = 0; k < N; k++) begin
          j = (rr_ptr + k) % N;
          if (sel < 0 && v[j]) sel = j;
        end
      end
    end
    e.rdy = '0; e.ov = 1'b0; e.od = '0; e.ol = 1'b0;
    if (sel >= 0) begin
      e.ov = v[sel]; e.od = d[sel]; e.ol = l[sel]; e.rdy[sel] = r;
    end
    xf = e.ov && r;
    xs = xf ? sel : -1;
    if (xf) begin
      f.d = e.od; f.l = e.ol;
      fq.push_back(f);
    end
    e.bsy   = (owner >= 0);
    e.gid   = IW'(mgid);
    e.err   = m_err;
    e.known = init;
    e.gchk  = init && (owner >= 0 || gid_rst);
    cq.push_back(e);
    @(posedge clk);
    if (!rn) begin
      owner = -1; rr_ptr = 0; mgid = 0; wd_cnt = 0; m_err = 1'b0;
      init = 1'b1; gid_rst = 1'b1;
    end else begin
`ifdef OSD_DII_PKT_ARBITER_WATCHDOG_EN
      if (wd_cnt == T) m_err = 1'b1;
      if (owner >= 0 && !xf) wd_cnt = (wd_cnt < T) ? wd_cnt + 1 : wd_cnt;
      else wd_cnt = 0;
`endif
      if (xf) begin
        if (owner < 0) begin
          rr_ptr = (sel + 1) % N;
          if (!e.ol) begin
            owner = sel; mgid = sel; gid_rst = 1'b0;
          end
        end else if (e.ol) owner = -1;
      end
    end
    #1;
  endtask

  task automatic clr();
    v = '0; l = '0; r = 1'b1; rn = 1'b1;
    for (int i = 0; i < N; i++) d[i] = '0;
  endtask

  task automatic one(input int s, input logic [15:0] dd, input logic ll, input logic vv);
    int xs;
    clr();
    v[s] = vv; d[s] = dd; l[s] = ll;
    cyc(xs);
  endtask

  task automatic run_random(input int ncyc);
    int xs;
    for (int c = 0; c < ncyc; c++) begin
      clr();
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 99) < vpct);
        d[i] = {4'(i), 12'(seq[i])};
        l[i] = (rem[i] == 1);
      end
      r = ($urandom_range(0, 99) < rpct);
      cyc(xs);
      if (xs >= 0) begin
        seq[xs]++;
        rem[xs]--;
        if (rem[xs] == 0) rem[xs] = $urandom_range(len_lo, len_hi);
      end
    end
  endtask

  initial begin
    int xs;
    in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0; rst = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; rem[i] = 1; end

    // Reset held with every input requesting: nothing may be granted
    clr(); rn = 1'b0; v = '1; l = '1;
    for (int i = 0; i < N; i++) d[i] = 16'hA000 + 16'(i);
    cyc(xs); cyc(xs);

    // Single requester: stream 2, three flits, then ptr=3 decides a 0-vs-3 race
    one(2, 16'h1111, 1'b0, 1'b1);
    one(2, 16'h2222, 1'b0, 1'b1);
    one(2, 16'h3333, 1'b1, 1'b1);
    clr(); v[0] = 1'b1; v[3] = 1'b1; l = '1; d[0] = 16'h0F00; d[3] = 16'h3F00;
    cyc(xs);
    clr(); v[0] = 1'b1; l = '1; d[0] = 16'h0F00;
    cyc(xs);
    clr(); cyc(xs);

    // All four streams continuously offering 2-flit packets
    len_lo = 2; len_hi = 2; vpct = 100; rpct = 100;
    for (int i = 0; i < N; i++) rem[i] = 2;
    run_random(24);

    // Backpressure mid-packet on stream 1 with stream 0 also requesting
    one(1, 16'hB001, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      clr(); v[1] = 1'b1; d[1] = 16'hB002; v[0] = 1'b1; d[0] = 16'h0B00; r = 1'b0;
      cyc(xs);
    end
    one(1, 16'hB002, 1'b0, 1'b1);
    one(1, 16'hB003, 1'b1, 1'b1);

    // Granted stream stalls well past the watchdog threshold, then finishes
    one(0, 16'hC001, 1'b0, 1'b1);
    for (int c = 0; c < T + 4; c++) begin
      clr(); v[2] = 1'b1; d[2] = 16'h2C00; d[0] = 16'hC002;
      cyc(xs);
    end
    one(0, 16'hC002, 1'b1, 1'b1);
    one(0, 16'h0000, 1'b0, 1'b0);
    one(0, 16'h0000, 1'b0, 1'b0);

    // Reset during flit 2 of a 4-flit stream-3 packet; the rest re-arbitrates
    one(3, 16'hD001, 1'b0, 1'b1);
    clr(); rn = 1'b0; v[3] = 1'b1; d[3] = 16'hD002; cyc(xs);
    clr(); rn = 1'b0; v[3] = 1'b1; d[3] = 16'hD002; cyc(xs);
    one(3, 16'hD002, 1'b0, 1'b1);
    one(3, 16'hD003, 1'b0, 1'b1);
    one(3, 16'hD004, 1'b1, 1'b1);

    // Long randomized traffic
    len_lo = 1; len_hi = 4; vpct = 70; rpct = 80;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(len_lo, len_hi);
    run_random(3000);

    clr(); cyc(xs);
    @(negedge clk); #1;
    chk("flits_left", 32'(fq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
